// File: rtl/usb_pkg.sv
// usb_pkg: PID codes, endpoint numbers, transaction states and the
// sender request bundle shared by the host read/write controller.
package usb_pkg;

    typedef enum logic [3:0] {
        OUT   = 4'b0001,
        IN    = 4'b1001,
        DATA0 = 4'b0011,
        ACK   = 4'b0010,
        NAK   = 4'b1010
    } pid_t;

    localparam logic [3:0] ENDP_ADDR = 4'd4;
    localparam logic [3:0] ENDP_DATA = 4'd8;

    typedef enum logic [3:0] {
        IDLE,
        ADDR_TOKEN,
        ADDR_DATA,
        ADDR_WAIT,
        RD_TOKEN,
        RD_WAIT,
        RD_HS,
        WR_TOKEN,
        WR_DATA,
        WR_WAIT,
        FINISH
    } txn_state_t;

    typedef struct packed {
        logic        req;
        logic [3:0]  pid;
        logic [3:0]  endp;
        logic [63:0] data;
    } tx_t;

    // Sender request presented while in state s. Tokens carry the
    // device address in data[6:0]; data-less packets use endpoint 0.
    function automatic tx_t tx_for(
        input txn_state_t  s,
        input logic [6:0]  addr,
        input logic [15:0] page,
        input logic [63:0] wdata,
        input logic        hs_ack
    );
        tx_t t;
        t = '0;
        unique case (s)
            ADDR_TOKEN: t = '{1'b1, OUT, ENDP_ADDR, {57'd0, addr}};
            ADDR_DATA:  t = '{1'b1, DATA0, 4'd0, {48'd0, page}};
            RD_TOKEN:   t = '{1'b1, IN, ENDP_DATA, {57'd0, addr}};
            RD_HS:      t = '{1'b1, hs_ack ? ACK : NAK, 4'd0, 64'd0};
            WR_TOKEN:   t = '{1'b1, OUT, ENDP_DATA, {57'd0, addr}};
            WR_DATA:    t = '{1'b1, DATA0, 4'd0, wdata};
            default:    t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rw_timeout_timer.sv
// rw_timeout_timer: response timer for the WAIT states.
// i_clear zeroes, i_en counts; o_expired while enabled at TIMEOUT.
module rw_timeout_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] r_cnt;
    logic         w_at_max;

    assign w_at_max  = (r_cnt == W'(TIMEOUT));
    assign o_expired = i_en && w_at_max;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/usb_rw_txn_fsm.sv
// usb_rw_txn_fsm: host read/write transaction controller. Turns a
// rd_start/wr_start request into token/data/handshake packets on the
// tx_req/tx_done sender port, consumes rec_* receiver pulses, retries
// NAK/corrupt/timeout failures per phase, reports done/success/rd_data.
// Macro RW_TXN_STATS_EN adds total_retries (saturating failure count).
module usb_rw_txn_fsm
    import usb_pkg::*;
#(
    parameter int         MAX_RETRY = 8,
    parameter int         TIMEOUT   = 255,
    parameter logic [6:0] DEV_ADDR  = 7'd5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rd_start,
    input  logic        wr_start,
    input  logic [15:0] mempage,
    input  logic [63:0] wr_data,
    input  logic        rec_ACK,
    input  logic        rec_NAK,
    input  logic        rec_DATA0,
    input  logic [63:0] data_rec,
    input  logic        data_valid,
    input  logic        tx_done,
    output logic        tx_req,
    output logic [3:0]  tx_pid,
    output logic [3:0]  tx_endp,
    output logic [63:0] tx_data,
    output logic        busy,
    output logic        done,
    output logic        success,
`ifdef RW_TXN_STATS_EN
    output logic [15:0] total_retries,
`endif
    output logic [63:0] rd_data
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    txn_state_t    r_state;
    txn_state_t    w_nxt;
    tx_t           r_tx;
    logic          r_busy;
    logic          r_done;
    logic          r_success;
    logic          r_is_rd;
    logic          r_hs_ack;
    logic [15:0]   r_page;
    logic [63:0]   r_wdata;
    logic [63:0]   r_rd_data;
    logic [RW-1:0] r_retry;

    logic w_fail;
    logic w_newph;
    logic w_ok;
    logic w_latch;
    logic w_hs_ack;
    logic w_in_wait;
    logic w_nxt_wait;
    logic w_expired;

    assign w_in_wait  = (r_state == ADDR_WAIT) || (r_state == RD_WAIT)
                     || (r_state == WR_WAIT);
    assign w_nxt_wait = (w_nxt == ADDR_WAIT) || (w_nxt == RD_WAIT)
                     || (w_nxt == WR_WAIT);
    // Handshake type is decided on the RD_WAIT exit and held in RD_HS.
    assign w_hs_ack   = (r_state == RD_WAIT) ? data_valid : r_hs_ack;

    rw_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_clear   (w_nxt_wait && (w_nxt != r_state)),
        .i_en      (w_in_wait),
        .o_expired (w_expired)
    );

    // Responses are tested before w_expired so a packet landing on the
    // expiry cycle is taken and the timeout is not counted.
    always_comb begin
        w_nxt   = r_state;
        w_fail  = 1'b0;
        w_newph = 1'b0;
        w_ok    = 1'b0;
        w_latch = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (rd_start || wr_start) begin
                    w_nxt   = ADDR_TOKEN;
                    w_newph = 1'b1;
                end
            end
            ADDR_TOKEN: if (tx_done) w_nxt = ADDR_DATA;
            ADDR_DATA:  if (tx_done) w_nxt = ADDR_WAIT;
            ADDR_WAIT: begin
                if (rec_ACK) begin
                    w_nxt   = r_is_rd ? RD_TOKEN : WR_TOKEN;
                    w_newph = 1'b1;
                end else if (rec_NAK || w_expired) begin
                    w_nxt  = ADDR_TOKEN;
                    w_fail = 1'b1;
                end
            end
            RD_TOKEN: if (tx_done) w_nxt = RD_WAIT;
            RD_WAIT: begin
                if (rec_DATA0) begin
                    w_nxt   = RD_HS;
                    w_latch = data_valid;
                end else if (rec_ACK || rec_NAK || w_expired) begin
                    w_nxt  = RD_TOKEN;
                    w_fail = 1'b1;
                end
            end
            RD_HS: begin
                if (tx_done) begin
                    if (r_hs_ack) begin
                        w_nxt = FINISH;
                        w_ok  = 1'b1;
                    end else begin
                        w_nxt  = RD_TOKEN;
                        w_fail = 1'b1;
                    end
                end
            end
            WR_TOKEN: if (tx_done) w_nxt = WR_DATA;
            WR_DATA:  if (tx_done) w_nxt = WR_WAIT;
            WR_WAIT: begin
                if (rec_ACK) begin
                    w_nxt = FINISH;
                    w_ok  = 1'b1;
                end else if (rec_NAK || w_expired) begin
                    w_nxt  = WR_TOKEN;
                    w_fail = 1'b1;
                end
            end
            FINISH:  w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
        if (w_fail && (r_retry == RW'(MAX_RETRY - 1))) begin
            w_nxt = FINISH;
        end
    end

    // Outputs are registered from the next state so they line up with
    // the state they belong to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_tx      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_success <= 1'b0;
            r_is_rd   <= 1'b0;
            r_hs_ack  <= 1'b0;
            r_page    <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
            r_retry   <= '0;
        end else begin
            r_state   <= w_nxt;
            r_tx      <= tx_for(w_nxt, DEV_ADDR, r_page, r_wdata, w_hs_ack);
            r_busy    <= (w_nxt != IDLE) && (w_nxt != FINISH);
            r_done    <= (w_nxt == FINISH);
            r_success <= w_ok;
            r_hs_ack  <= w_hs_ack;
            if (r_state == IDLE && (rd_start || wr_start)) begin
                r_is_rd <= rd_start;
                r_page  <= mempage;
                r_wdata <= wr_data;
            end
            if (w_newph) begin
                r_retry <= '0;
            end else if (w_fail) begin
                r_retry <= r_retry + 1'b1;
            end
            if (w_latch) begin
                r_rd_data <= data_rec;
            end
        end
    end

`ifdef RW_TXN_STATS_EN
    logic [15:0] r_total;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_total <= '0;
        end else if (w_fail && (r_total != 16'hFFFF)) begin
            r_total <= r_total + 16'd1;
        end
    end

    assign total_retries = r_total;
`endif

    assign tx_req  = r_tx.req;
    assign tx_pid  = r_tx.pid;
    assign tx_endp = r_tx.endp;
    assign tx_data = r_tx.data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign success = r_success;
    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_usb_rw_txn_fsm.sv
// tb_usb_rw_txn_fsm: scoreboard bench; a sender/device model checks
// each packet against a queue, a monitor checks each done pulse.
module tb_usb_rw_txn_fsm;
    import usb_pkg::*;

    localparam int TO     = 255;
    localparam int R_NONE = 0;
    localparam int R_ACK  = 1;
    localparam int R_NAK  = 2;
    localparam int R_DGD  = 3;
    localparam int R_DBAD = 4;
    localparam logic [63:0] TOKD = 64'd5;

    typedef struct {
        logic [3:0]  pid;
        logic [3:0]  endp;
        logic [63:0] data;
        int          rsp;
        int          dly;
        logic [63:0] rdat;
        int          mark;
    } pkt_t;

    typedef struct {
        logic        ok;
        logic [63:0] rd;
    } dn_t;

    logic        clock;
    logic        reset_n;
    logic        rd_start;
    logic        wr_start;
    logic [15:0] mempage;
    logic [63:0] wr_data;
    logic        rec_ACK;
    logic        rec_NAK;
    logic        rec_DATA0;
    logic [63:0] data_rec;
    logic        data_valid;
    logic        tx_done;
    logic        tx_req;
    logic [3:0]  tx_pid;
    logic [3:0]  tx_endp;
    logic [63:0] tx_data;
    logic        busy;
    logic        done;
    logic        success;
    logic [63:0] rd_data;
`ifdef RW_TXN_STATS_EN
    logic [15:0] total_retries;
`endif

    usb_rw_txn_fsm dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rd_start   (rd_start),
        .wr_start   (wr_start),
        .mempage    (mempage),
        .wr_data    (wr_data),
        .rec_ACK    (rec_ACK),
        .rec_NAK    (rec_NAK),
        .rec_DATA0  (rec_DATA0),
        .data_rec   (data_rec),
        .data_valid (data_valid),
        .tx_done    (tx_done),
        .tx_req     (tx_req),
        .tx_pid     (tx_pid),
        .tx_endp    (tx_endp),
        .tx_data    (tx_data),
        .busy       (busy),
        .done       (done),
        .success    (success),
`ifdef RW_TXN_STATS_EN
        .total_retries (total_retries),
`endif
        .rd_data    (rd_data)
    );

    pkt_t exp_pkt[$];
    dn_t  exp_dn[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t_start = 0;
    int   t_end = 0;
    logic [63:0] m_rd = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic void px(input logic [3:0] pid, input logic [3:0] endp,
                               input logic [63:0] data, input int rsp,
                               input int dly, input logic [63:0] rdat,
                               input int mark);
        pkt_t p;
        p.pid = pid; p.endp = endp; p.data = data;
        p.rsp = rsp; p.dly = dly; p.rdat = rdat; p.mark = mark;
        exp_pkt.push_back(p);
    endfunction

    function automatic void pdone(input logic ok, input logic [63:0] rd);
        dn_t d;
        d.ok = ok; d.rd = rd;
        exp_dn.push_back(d);
    endfunction

    function automatic void addr(input logic [15:0] pg, input int rsp,
                                 input int dly);
        px(OUT, 4'd4, TOKD, R_NONE, 0, '0, 0);
        px(DATA0, 4'd0, {48'd0, pg}, rsp, dly, '0, 0);
    endfunction

    // Sender and device model: completes each request, then plays the
    // scripted response into the WAIT state.
    initial begin
        pkt_t e;
        tx_done = 0; rec_ACK = 0; rec_NAK = 0; rec_DATA0 = 0;
        data_valid = 0; data_rec = '0;
        forever begin
            @(negedge clock);
            if (tx_req === 1'b1) begin
                if (exp_pkt.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pkt: got pid %h endp %h, expected none",
                             tx_pid, tx_endp);
                    e.rsp = R_NONE; e.mark = 0;
                end else begin
                    e = exp_pkt.pop_front();
                    chk("pkt_pid", {60'd0, tx_pid}, {60'd0, e.pid});
                    chk("pkt_endp", {60'd0, tx_endp}, {60'd0, e.endp});
                    chk("pkt_data", tx_data, e.data);
                    if (e.mark == 2) t_end = cyc;
                end
                repeat (2) @(negedge clock);
                tx_done = 1;
                @(negedge clock);
                tx_done = 0;
                if (e.mark == 1) t_start = cyc;
                if (e.rsp != R_NONE) begin
                    repeat (e.dly) @(negedge clock);
                    rec_ACK    = (e.rsp == R_ACK);
                    rec_NAK    = (e.rsp == R_NAK);
                    rec_DATA0  = (e.rsp == R_DGD) || (e.rsp == R_DBAD);
                    data_valid = (e.rsp == R_DGD);
                    data_rec   = e.rdat;
                    @(negedge clock);
                    rec_ACK = 0; rec_NAK = 0; rec_DATA0 = 0; data_valid = 0;
                end
            end
        end
    end

    initial begin
        dn_t d;
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                if (exp_dn.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1, expected 0");
                end else begin
                    d = exp_dn.pop_front();
                    chk("done_success", {63'd0, success}, {63'd0, d.ok});
                    chk("done_rd_data", rd_data, d.rd);
                    chk("done_busy", {63'd0, busy}, 64'd0);
                end
            end
        end
    end

    task automatic start(input logic rd, input logic wr,
                         input logic [15:0] pg, input logic [63:0] wd);
        @(negedge clock);
        rd_start = rd; wr_start = wr; mempage = pg; wr_data = wd;
        @(negedge clock);
        rd_start = 0; wr_start = 0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_txn(input string nm, input bit need_done);
        int n;
        n = 0;
        while ((exp_pkt.size() != 0 || (need_done && exp_dn.size() != 0))
               && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s: %0d pkts %0d dones pending after %0d cycles, expected 0",
                     nm, exp_pkt.size(), exp_dn.size(), n);
            exp_pkt.delete();
            exp_dn.delete();
            reset_n = 0;
            repeat (2) @(negedge clock);
            reset_n = 1;
            m_rd = '0;
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_tx_req"}, {63'd0, tx_req}, 64'd0);
        chk({nm, "_tx_pid"}, {60'd0, tx_pid}, 64'd0);
        chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
        chk({nm, "_done"}, {63'd0, done}, 64'd0);
        chk({nm, "_success"}, {63'd0, success}, 64'd0);
        chk({nm, "_rd_data"}, rd_data, 64'd0);
    endtask

    initial begin
        reset_n = 0; rd_start = 0; wr_start = 0;
        mempage = '0; wr_data = '0;
        repeat (3) @(negedge clock);
        chk_zero("reset");
        reset_n = 1;
        repeat (2) @(negedge clock);

        // clean write
        addr(16'h0123, R_ACK, 3);
        px(OUT, 4'd8, TOKD, R_NONE, 0, '0, 0);
        px(DATA0, 4'd0, 64'hDEADBEEF_CAFEF00D, R_ACK, 3, '0, 0);
        pdone(1'b1, m_rd);
        start(1'b0, 1'b1, 16'h0123, 64'hDEADBEEF_CAFEF00D);
        wait_txn("clean_write", 1'b1);

        // clean read, with a stray wr_start while busy
        addr(16'h0042, R_ACK, 2);
        px(IN, 4'd8, TOKD, R_DGD, 3, 64'h11223344_55667788, 0);
        px(ACK, 4'd0, 64'd0, R_NONE, 0, '0, 0);
        m_rd = 64'h11223344_55667788;
        pdone(1'b1, m_rd);
        start(1'b1, 1'b0, 16'h0042, '0);
        repeat (3) @(negedge clock);
        wr_start = 1; mempage = 16'hFFFF;
        @(negedge clock);
        wr_start = 0;
        wait_txn("clean_read", 1'b1);

        // corrupt, corrupt, good
        addr(16'h0077, R_ACK, 1);
        for (int i = 0; i < 2; i++) begin
            px(IN, 4'd8, TOKD, R_DBAD, 4, 64'hBAD0BAD0_BAD0BAD0, 0);
            px(NAK, 4'd0, 64'd0, R_NONE, 0, '0, 0);
        end
        px(IN, 4'd8, TOKD, R_DGD, 0, 64'hA5A50000_5A5AFFFF, 0);
        px(ACK, 4'd0, 64'd0, R_NONE, 0, '0, 0);
        m_rd = 64'hA5A50000_5A5AFFFF;
        pdone(1'b1, m_rd);
        start(1'b1, 1'b0, 16'h0077, '0);
        wait_txn("corrupt_read", 1'b1);

        // retry exhaustion: 8 address attempts, rd_data kept
        for (int i = 0; i < 8; i++) addr(16'h0099, R_NAK, 2);
        pdone(1'b0, m_rd);
        start(1'b1, 1'b0, 16'h0099, '0);
        wait_txn("retry_exhaust", 1'b1);

        // timeout then response exactly on the expiry cycle
        px(OUT, 4'd4, TOKD, R_NONE, 0, '0, 0);
        px(DATA0, 4'd0, 64'h0200, R_NONE, 0, '0, 1);
        px(OUT, 4'd4, TOKD, R_NONE, 0, '0, 2);
        px(DATA0, 4'd0, 64'h0200, R_ACK, TO, '0, 0);
        px(OUT, 4'd8, TOKD, R_NONE, 0, '0, 0);
        px(DATA0, 4'd0, 64'h01234567_89ABCDEF, R_ACK, 1, '0, 0);
        pdone(1'b1, m_rd);
        start(1'b0, 1'b1, 16'h0200, 64'h01234567_89ABCDEF);
        wait_txn("timeout", 1'b1);
        chk("timeout_retry_gap", 64'(t_end - t_start), 64'(TO + 1));

        // reset while in RD_WAIT
        addr(16'h0300, R_ACK, 2);
        px(IN, 4'd8, TOKD, R_NONE, 0, '0, 0);
        start(1'b1, 1'b0, 16'h0300, '0);
        wait_txn("reset_setup", 1'b0);
        repeat (5) @(negedge clock);
        reset_n = 0;
        @(negedge clock);
        chk_zero("midreset");
        reset_n = 1;
        m_rd = '0;
        repeat (10) @(negedge clock);

        // simultaneous starts: read wins
        addr(16'h0555, R_ACK, 2);
        px(IN, 4'd8, TOKD, R_DGD, 1, 64'h0F0E0D0C_0B0A0908, 0);
        px(ACK, 4'd0, 64'd0, R_NONE, 0, '0, 0);
        m_rd = 64'h0F0E0D0C_0B0A0908;
        pdone(1'b1, m_rd);
        start(1'b1, 1'b1, 16'h0555, 64'hFFFFFFFF_FFFFFFFF);
        wait_txn("start_collision", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
